// File: rtl/virtio_avail_notify_tracker.sv
// Virtqueue front end: records queue-notify doorbells, fetches each notified
// queue's avail ring idx field and publishes per-queue "ring available" flags.
module virtio_avail_notify_tracker #(
   parameter int unsigned NUM_QUEUES = 3,
   parameter int unsigned ADDR_W     = 64
) (
   input  logic                         clk,
   input  logic                         csr_rst,
   input  logic [NUM_QUEUES-1:0]        queue_enable,
   input  logic [NUM_QUEUES*ADDR_W-1:0] avail_base,
   input  logic                         notify_valid,
   input  logic [1:0]                   notify_queue,
   output logic                         rd_req_valid,
   input  logic                         rd_req_ready,
   output logic [ADDR_W-1:0]            rd_req_addr,
   input  logic                         rd_resp_valid,
   input  logic [15:0]                  rd_resp_data,
   input  logic [NUM_QUEUES-1:0]        ring_available_clr,
   output logic [NUM_QUEUES-1:0]        queue_notify_pending,
   output logic [NUM_QUEUES-1:0]        ring_available_pending,
   output logic [NUM_QUEUES*16-1:0]     next_avail_idx,
   output logic                         busy
);

   localparam int unsigned QW    = 2;
   localparam int unsigned IDX_W = 16;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                 state;
   logic [QW-1:0]          cur_q;
   logic [QW-1:0]          rr_ptr;
   logic [QW-1:0]          rr_next;
   logic [NUM_QUEUES-1:0]  notify_set;
   logic [NUM_QUEUES-1:0]  notify_clr;
   logic [NUM_QUEUES-1:0]  avail_set;
   logic                   pick_valid;
   logic [QW-1:0]          pick_q;
   logic [ADDR_W-1:0]      pick_addr;
   logic [QW-1:0]          cand_q;
   logic [IDX_W-1:0]       cur_idx;

   // Doorbell decode: only in-range, enabled queues record a notify
   always_comb begin
      notify_set = '0;
      for (int q = 0; q < int'(NUM_QUEUES); q++) begin
         if (notify_valid && notify_queue == QW'(q) && queue_enable[q])
            notify_set[q] = 1'b1;
      end
   end

   // Round-robin pick of the next pending queue, starting at rr_ptr
   always_comb begin
      pick_valid = 1'b0;
      pick_q     = '0;
      pick_addr  = '0;
      cand_q     = '0;
      for (int i = 0; i < int'(NUM_QUEUES); i++) begin
         cand_q = QW'((int'(rr_ptr) + i) % int'(NUM_QUEUES));
         for (int q = 0; q < int'(NUM_QUEUES); q++) begin
            if (!pick_valid && cand_q == QW'(q) && queue_notify_pending[q]) begin
               pick_valid = 1'b1;
               pick_q     = QW'(q);
               pick_addr  = avail_base[q*ADDR_W +: ADDR_W] + ADDR_W'(2);
            end
         end
      end
   end

   // Current-queue index lookup and per-queue set/clear strobes
   always_comb begin
      cur_idx    = '0;
      notify_clr = '0;
      avail_set  = '0;
      for (int q = 0; q < int'(NUM_QUEUES); q++) begin
         if (cur_q == QW'(q)) begin
            cur_idx = next_avail_idx[q*IDX_W +: IDX_W];
            if (state == REQ && rd_req_ready)
               notify_clr[q] = 1'b1;
         end
      end
      for (int q = 0; q < int'(NUM_QUEUES); q++) begin
         if (cur_q == QW'(q) && state == WAIT && rd_resp_valid && rd_resp_data != cur_idx)
            avail_set[q] = 1'b1;
      end
      rr_next = (cur_q == QW'(NUM_QUEUES - 1)) ? '0 : cur_q + QW'(1);
   end

   // Pending flags, index store and the IDLE/REQ/WAIT fetch sequencer
   always_ff @(posedge clk) begin
      if (csr_rst) begin
         state                  <= IDLE;
         cur_q                  <= '0;
         rr_ptr                 <= '0;
         rd_req_valid           <= 1'b0;
         rd_req_addr            <= '0;
         queue_notify_pending   <= '0;
         ring_available_pending <= '0;
         next_avail_idx         <= '0;
         busy                   <= 1'b0;
      end else begin
         queue_notify_pending   <= (queue_notify_pending & ~notify_clr) | notify_set;
         ring_available_pending <= (ring_available_pending & ~ring_available_clr) | avail_set;
         for (int q = 0; q < int'(NUM_QUEUES); q++) begin
            if (avail_set[q])
               next_avail_idx[q*IDX_W +: IDX_W] <= rd_resp_data;
         end
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  cur_q        <= pick_q;
                  rd_req_addr  <= pick_addr;
                  rd_req_valid <= 1'b1;
                  busy         <= 1'b1;
                  state        <= REQ;
               end
            end
            REQ: begin
               if (rd_req_ready) begin
                  rd_req_valid <= 1'b0;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               if (rd_resp_valid) begin
                  rr_ptr <= rr_next;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               rd_req_valid <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_virtio_avail_notify_tracker.sv
// Bench for virtio_avail_notify_tracker: directed scenarios plus randomized
// traffic, all outputs compared every cycle against a queue-level model.
module tb_virtio_avail_notify_tracker;

   logic          clk = 1'b0;
   logic          csr_rst;
   logic [2:0]    queue_enable;
   logic [63:0]   tb_base [3];
   logic [191:0]  avail_base;
   logic          notify_valid;
   logic [1:0]    notify_queue;
   logic          rd_req_valid;
   logic          rd_req_ready;
   logic [63:0]   rd_req_addr;
   logic          rd_resp_valid;
   logic [15:0]   rd_resp_data;
   logic [2:0]    ring_available_clr;
   logic [2:0]    queue_notify_pending;
   logic [2:0]    ring_available_pending;
   logic [47:0]   next_avail_idx;
   logic          busy;

   int total = 0;
   int bad   = 0;

   // Model: phase 0 idle, 1 request outstanding, 2 awaiting response
   int            m_phase = 0;
   int            m_q     = 0;
   int            m_rr    = 0;
   bit            m_valid = 1'b0;
   logic [63:0]   m_addr  = '0;
   bit            m_np [3];
   bit            m_ap [3];
   logic [15:0]   m_idx [3];

   assign avail_base = {tb_base[2], tb_base[1], tb_base[0]};

   always #5 clk = ~clk;

   virtio_avail_notify_tracker dut (
      .clk                    (clk),
      .csr_rst                (csr_rst),
      .queue_enable           (queue_enable),
      .avail_base             (avail_base),
      .notify_valid           (notify_valid),
      .notify_queue           (notify_queue),
      .rd_req_valid           (rd_req_valid),
      .rd_req_ready           (rd_req_ready),
      .rd_req_addr            (rd_req_addr),
      .rd_resp_valid          (rd_resp_valid),
      .rd_resp_data           (rd_resp_data),
      .ring_available_clr     (ring_available_clr),
      .queue_notify_pending   (queue_notify_pending),
      .ring_available_pending (ring_available_pending),
      .next_avail_idx         (next_avail_idx),
      .busy                   (busy)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs about to be sampled
   task automatic model_step();
      bit nset [3];
      bit nclr [3];
      bit aset [3];
      bit found;
      int q;
      if (csr_rst) begin
         m_phase = 0; m_q = 0; m_rr = 0; m_valid = 1'b0; m_addr = '0;
         for (int i = 0; i < 3; i++) begin
            m_np[i] = 1'b0; m_ap[i] = 1'b0; m_idx[i] = '0;
         end
         return;
      end
      for (int i = 0; i < 3; i++) begin
         nset[i] = notify_valid && (int'(notify_queue) == i) && queue_enable[i];
         nclr[i] = 1'b0;
         aset[i] = 1'b0;
      end
      found = 1'b0;
      case (m_phase)
         0: begin
            for (int i = 0; i < 3; i++) begin
               q = (m_rr + i) % 3;
               if (!found && m_np[q]) begin
                  found   = 1'b1;
                  m_q     = q;
                  m_addr  = tb_base[q] + 64'd2;
                  m_valid = 1'b1;
                  m_phase = 1;
               end
            end
         end
         1: begin
            if (rd_req_ready) begin
               nclr[m_q] = 1'b1;
               m_valid   = 1'b0;
               m_phase   = 2;
            end
         end
         default: begin
            if (rd_resp_valid) begin
               if (rd_resp_data != m_idx[m_q]) begin
                  m_idx[m_q] = rd_resp_data;
                  aset[m_q]  = 1'b1;
               end
               m_rr    = (m_q + 1) % 3;
               m_phase = 0;
            end
         end
      endcase
      for (int i = 0; i < 3; i++) begin
         m_np[i] = (m_np[i] && !nclr[i]) || nset[i];
         m_ap[i] = (m_ap[i] && !ring_available_clr[i]) || aset[i];
      end
   endtask

   // Compare every DUT output with the model
   task automatic compare_all();
      logic [2:0]  e_np;
      logic [2:0]  e_ap;
      logic [47:0] e_idx;
      for (int i = 0; i < 3; i++) begin
         e_np[i] = m_np[i];
         e_ap[i] = m_ap[i];
      end
      e_idx = {m_idx[2], m_idx[1], m_idx[0]};
      check_val("notify_pending", 64'(queue_notify_pending), 64'(e_np));
      check_val("avail_pending", 64'(ring_available_pending), 64'(e_ap));
      check_val("next_idx", 64'(next_avail_idx), 64'(e_idx));
      check_val("req_valid", 64'(rd_req_valid), 64'(m_valid));
      check_val("req_addr", rd_req_addr, m_addr);
      check_val("busy", 64'(busy), 64'(m_phase != 0));
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic serve(input int exp_q, input logic [15:0] data, input int stall, input logic [2:0] clr);
      logic [63:0] a0;
      int n;
      n = 0;
      while (!rd_req_valid && n < 20) begin
         step();
         n++;
      end
      check_val("req_seen", 64'(rd_req_valid), 64'd1);
      a0 = rd_req_addr;
      check_val("req_addr_q", a0, tb_base[exp_q] + 64'd2);
      for (int s = 0; s < stall; s++) begin
         step();
         check_val("addr_stable", rd_req_addr, a0);
      end
      rd_req_ready = 1'b1;
      step();
      rd_req_ready = 1'b0;
      rd_resp_valid = 1'b1;
      rd_resp_data = data;
      ring_available_clr = clr;
      step();
      rd_resp_valid = 1'b0;
      ring_available_clr = '0;
   endtask

   task automatic notify(input logic [1:0] q);
      notify_valid = 1'b1;
      notify_queue = q;
      step();
      notify_valid = 1'b0;
   endtask

   // Random memory/doorbell traffic driven from the model's view
   task automatic rand_inputs();
      csr_rst            = ($urandom_range(0, 399) == 0);
      notify_valid       = ($urandom_range(0, 3) == 0);
      notify_queue       = 2'($urandom_range(0, 3));
      rd_req_ready       = ($urandom_range(0, 2) == 0);
      rd_resp_valid      = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      ring_available_clr = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 49) == 0)
         queue_enable = 3'($urandom) | 3'($urandom);
      if ($urandom_range(0, 99) == 0)
         tb_base[$urandom_range(0, 2)] = {$urandom, $urandom};
      case ($urandom_range(0, 3))
         0:       rd_resp_data = 16'($urandom);
         1:       rd_resp_data = m_idx[m_q] + 16'd1;
         2:       rd_resp_data = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
         default: rd_resp_data = m_idx[m_q];
      endcase
   endtask

   initial begin
      csr_rst = 1'b1; queue_enable = 3'b111;
      notify_valid = 1'b0; notify_queue = '0;
      rd_req_ready = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0;
      ring_available_clr = '0;
      tb_base[0] = 64'h0000_0000_0000_2000;
      tb_base[1] = 64'h0000_0000_0000_1000;
      tb_base[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      #2;
      step(); step();
      csr_rst = 1'b0;
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_idx", 64'(next_avail_idx), 64'd0);

      // New entries on q1
      notify(2'd1);
      check_val("s1_pending", 64'(queue_notify_pending), 64'h2);
      step();
      check_val("s1_addr", rd_req_addr, 64'h1002);
      serve(1, 16'h0005, 0, 3'b000);
      check_val("s1_idx", 64'(next_avail_idx[31:16]), 64'h5);
      check_val("s1_avail", 64'(ring_available_pending), 64'h2);
      check_val("s1_np", 64'(queue_notify_pending), 64'h0);

      // Spurious notify: same index
      notify(2'd1);
      serve(1, 16'h0005, 0, 3'b000);
      check_val("s2_avail", 64'(ring_available_pending), 64'h2);
      check_val("s2_idx", 64'(next_avail_idx[31:16]), 64'h5);
      ring_available_clr = 3'b010;
      step();
      ring_available_clr = '0;

      // Back-to-back notifies with stalled read port, address wraps on q2
      notify(2'd0); notify(2'd1); notify(2'd2);
      serve(0, 16'h0100, 3, 3'b000);
      serve(1, 16'h0101, 3, 3'b000);
      serve(2, 16'h0102, 3, 3'b000);
      check_val("s3_addr2", rd_req_addr, 64'h1);

      // Index wrap and set-beats-clear
      ring_available_clr = 3'b111;
      step();
      ring_available_clr = '0;
      notify(2'd2);
      serve(2, 16'hFFFF, 0, 3'b000);
      notify(2'd2);
      serve(2, 16'h0000, 0, 3'b100);
      check_val("s4_flag", 64'(ring_available_pending[2]), 64'd1);
      check_val("s4_idx", 64'(next_avail_idx[47:32]), 64'h0);

      // Out-of-range and disabled-queue notifies are dropped
      notify(2'd3);
      queue_enable = 3'b110;
      notify(2'd0);
      step(); step();
      check_val("s5_np", 64'(queue_notify_pending), 64'h0);
      check_val("s5_req", 64'(rd_req_valid), 64'd0);
      queue_enable = 3'b111;

      // Reset while awaiting the response, then a late response
      notify(2'd1);
      step();
      rd_req_ready = 1'b1;
      step();
      rd_req_ready = 1'b0;
      check_val("s6_wait", 64'(busy), 64'd1);
      csr_rst = 1'b1;
      step();
      csr_rst = 1'b0;
      rd_resp_valid = 1'b1;
      rd_resp_data = 16'h1234;
      step();
      rd_resp_valid = 1'b0;
      check_val("s6_avail", 64'(ring_available_pending), 64'h0);
      check_val("s6_busy", 64'(busy), 64'd0);
      check_val("s6_idx", 64'(next_avail_idx), 64'h0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/virtio_avail_notify_tracker.md
Name: virtio_avail_notify_tracker

Overview:
- Device-side virtqueue front end for the virtio FPGA shell with three split virtqueues.
- Records driver doorbell (queue-notify) writes from the CSR block for each queue.
- Fetches the avail ring `idx` field of each notified queue over a simple memory-read port.
- Publishes per-queue "ring available" pending flags and the latest avail index to the downstream descriptor-processing stage.

Parameters:
- NUM_QUEUES, 3, number of virtqueues tracked (fixed to 3 in this design; queue index field is 2 bits).
- ADDR_W, 64, width of guest-physical addresses.

Ports:
- clk  in  1  single clock for all logic.
- csr_rst  in  1  synchronous active-high reset.
- queue_enable  in  NUM_QUEUES  per-queue ready/enable from CSR; notifies to disabled queues are ignored.
- avail_base  in  NUM_QUEUES*ADDR_W  per-queue avail ring base address; queue q occupies bits [q*ADDR_W +: ADDR_W].
- notify_valid  in  1  one-cycle pulse: driver wrote the queue-notify register.
- notify_queue  in  2  queue index carried with notify_valid.
- rd_req_valid  out  1  memory read request valid.
- rd_req_ready  in  1  memory read request accepted.
- rd_req_addr  out  ADDR_W  byte address of the 16-bit avail `idx` field.
- rd_resp_valid  in  1  one-cycle read response strobe.
- rd_resp_data  in  16  avail `idx` value, little-endian, already aligned.
- ring_available_clr  in  NUM_QUEUES  downstream consumer clears the pending flag of queue q.
- queue_notify_pending  out  NUM_QUEUES  notify recorded and not yet serviced.
- ring_available_pending  out  NUM_QUEUES  new avail entries exist for queue q.
- next_avail_idx  out  NUM_QUEUES*16  latest avail `idx` read for each queue.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset, synchronous on csr_rst: all outputs 0, all pending flags 0, next_avail_idx all 0, FSM to IDLE, round-robin pointer 0. Asserting reset mid-transaction aborts the transaction: rd_req_valid drops next cycle and any later rd_resp_valid is ignored until a new request is issued.
- Notify capture:
  - notify_valid with notify_queue < NUM_QUEUES and queue_enable set → queue_notify_pending[q] = 1 at the next edge.
  - notify_queue = 3, or a disabled queue → no effect.
  - Per bit, set has priority over clear.
- FSM states IDLE, REQ, WAIT:
  - IDLE: if any queue_notify_pending bit is set, select the next set bit in round-robin order, starting after the last serviced queue. Latch q; go to REQ with rd_req_valid = 1.
  - rd_req_addr = avail_base[q] + 2, i.e. the `idx` field offset in the split ring.
  - REQ: hold rd_req_valid and rd_req_addr stable until rd_req_ready.
  - On the accept cycle: clear queue_notify_pending[q] unless a new notify for q arrives the same cycle (set wins); go to WAIT.
  - WAIT: on rd_resp_valid, compare rd_resp_data with next_avail_idx[q].
    - If different: next_avail_idx[q] = rd_resp_data and set ring_available_pending[q].
    - If equal: no flag change (spurious notify).
    - Advance the round-robin pointer past q; return to IDLE.
  - Minimum latency: notify pulse at cycle N → rd_req_valid at N+2 (N+1 pending, N+2 request). Response at cycle M → flag and index visible at M+1.
- ring_available_pending[q]:
  - Cleared by ring_available_clr[q].
  - A set and a clear in the same cycle → set wins.
  - Remains set across multiple updates; it is a level, not a count.
- Index comparison is full 16-bit equality, so wrap from 0xFFFF to 0x0000 counts as new entries. Address add is modulo 2^ADDR_W.
- rd_resp_valid outside WAIT is ignored. rd_req_ready outside REQ is ignored.
- busy = (state != IDLE).

Test Plan:
- Reset, then notify q1 with avail_base[1]=0x1000 → queue_notify_pending=3'b010; rd_req_addr=0x1002; response 0x0005 → next_avail_idx[1]=5, ring_available_pending=3'b010, queue_notify_pending=0.
- Repeat notify q1 with response 0x0005 → ring_available_pending unchanged; next_avail_idx[1]=5.
- Notify q0, q1, q2 in consecutive cycles with rd_req_ready held low 3 cycles → requests served in order 0,1,2; rd_req_addr stable while stalled.
- next_avail_idx[2]=0xFFFF, then response 0x0000 → flag set, index 0x0000. Same-cycle ring_available_set and ring_available_clr → flag stays 1.
- notify_queue=3, or queue_enable[0]=0 with notify q0 → no pending bit set, no request issued.
- csr_rst asserted in WAIT, then a late rd_resp_valid → all flags 0, state IDLE, next_avail_idx unchanged from reset value 0.
